// File: rtl/clic_pkg.sv
// Shared types for the CLIC interrupt transmit path: level width, the
// transmitter state encoding and the arbitration candidate record.
package clic_pkg;

  localparam int unsigned LevelWidth = 8;
  // Wide enough for any supported source count (up to 1024 sources).
  localparam int unsigned MaxIdWidth = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic                  valid;
    logic [MaxIdWidth-1:0] id;
    logic [LevelWidth-1:0] level;
  } irq_cand_t;

endpackage

// File: rtl/clic_irq_arb.sv
// Combinational max-level arbiter over all sources, built as a balanced
// comparator tree; ties go to the higher id.
module clic_irq_arb
  import clic_pkg::*;
#(
  parameter int unsigned NumSrc = 64
) (
  input  logic [NumSrc-1:0]            pending_i,
  input  logic [NumSrc-1:0]            enable_i,
  input  logic [NumSrc*LevelWidth-1:0] level_i,
  output irq_cand_t                    winner_o
);

  localparam int Depth  = $clog2(NumSrc);
  localparam int Leaves = 1 << Depth;

  // Heap layout: node 0 is the root, leaves start at Leaves-1.
  irq_cand_t node [2*Leaves-1];

  // The right operand always covers higher ids, so it wins equal levels.
  function automatic irq_cand_t pick(input irq_cand_t lo, input irq_cand_t hi);
    if (hi.valid && (!lo.valid || (hi.level >= lo.level))) begin
      return hi;
    end
    return lo;
  endfunction

  always_comb begin
    for (int i = 0; i < Leaves; i++) begin
      node[Leaves-1+i] = '0;
      if (i < int'(NumSrc)) begin
        node[Leaves-1+i].level = level_i[i*LevelWidth +: LevelWidth];
        node[Leaves-1+i].id    = MaxIdWidth'(i);
        node[Leaves-1+i].valid = pending_i[i] & enable_i[i] &
                                 (level_i[i*LevelWidth +: LevelWidth] != '0);
      end
    end
    for (int n = Leaves - 2; n >= 0; n--) begin
      node[n] = pick(node[2*n+1], node[2*n+2]);
    end
  end

  assign winner_o = node[0];

endmodule

// File: rtl/clic_irq_tx.sv
// CLIC-side interrupt transmitter: arbitrates, holds a one-hot request and
// level towards the core, withdraws it through a one-cycle gap, claims on ack.
module clic_irq_tx
  import clic_pkg::*;
#(
  parameter int unsigned NumSrc = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumSrc-1:0]           irq_pending_i,
  input  logic [NumSrc-1:0]           irq_enable_i,
  input  logic [NumSrc*8-1:0]         irq_level_i,
  output logic [NumSrc-1:0]           clic_irq_o,
  output logic [7:0]                  clic_irq_level_o,
  input  logic                        clic_irq_ack_i,
  input  logic [$clog2(NumSrc)-1:0]   clic_irq_ack_id_i,
  output logic                        claim_valid_o,
  output logic [$clog2(NumSrc)-1:0]   claim_id_o
);

  localparam int unsigned IdW = $clog2(NumSrc);

  tx_state_e                 state_q, state_d;
  logic [NumSrc-1:0]         irq_q, irq_d;
  logic [LevelWidth-1:0]     level_q, level_d;
  logic [IdW-1:0]            id_q, id_d;
  logic                      claim_valid_q, claim_valid_d;
  logic [IdW-1:0]            claim_id_q, claim_id_d;

  irq_cand_t                 win;
  logic [NumSrc-1:0]         arb_pending;
  logic [LevelWidth-1:0]     held_level;
  logic                      held_ok;
  logic                      preempt;

  // The held source is masked out so only other sources can preempt it;
  // irq_q is zero outside REQ, so IDLE/KILL see every source.
  assign arb_pending = irq_pending_i & ~irq_q;

  clic_irq_arb #(
    .NumSrc (NumSrc)
  ) u_arb (
    .pending_i (arb_pending),
    .enable_i  (irq_enable_i),
    .level_i   (irq_level_i),
    .winner_o  (win)
  );

  assign held_level = irq_level_i[{id_q, 3'b000} +: LevelWidth];
  assign held_ok    = irq_pending_i[id_q] & irq_enable_i[id_q] & (held_level != '0);
  assign preempt    = win.valid & (win.level > level_q);

  always_comb begin
    state_d       = state_q;
    irq_d         = irq_q;
    level_d       = level_q;
    id_d          = id_q;
    claim_valid_d = 1'b0;
    claim_id_d    = claim_id_q;

    if (clic_irq_ack_i) begin
      state_d       = IDLE;
      irq_d         = '0;
      level_d       = '0;
      id_d          = '0;
      claim_valid_d = 1'b1;
      claim_id_d    = clic_irq_ack_id_i;
    end else begin
      case (state_q)
        REQ: begin
          if (!held_ok || preempt) begin
            state_d = KILL;
            irq_d   = '0;
            level_d = '0;
            id_d    = '0;
          end
        end
        default: begin
          // IDLE and KILL both arbitrate; outputs are already zero here.
          if (win.valid) begin
            state_d = REQ;
            id_d    = win.id[IdW-1:0];
            level_d = win.level;
            for (int i = 0; i < int'(NumSrc); i++) begin
              irq_d[i] = (win.id == MaxIdWidth'(i));
            end
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      irq_q         <= '0;
      level_q       <= '0;
      id_q          <= '0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      irq_q         <= irq_d;
      level_q       <= level_d;
      id_q          <= id_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
    end
  end

  assign clic_irq_o       = irq_q;
  assign clic_irq_level_o = level_q;
  assign claim_valid_o    = claim_valid_q;
  assign claim_id_o       = claim_id_q;

endmodule

// File: tb/tb_clic_irq_tx.sv
// Bench for clic_irq_tx: directed scenarios plus a randomized run against a
// source-level reference model of the request/withdraw/claim rules.
module tb_clic_irq_tx;

  localparam int N = 64;

  logic           clk_i;
  logic           rst_ni;
  logic [N-1:0]   pend;
  logic [N-1:0]   en;
  logic [N*8-1:0] lvl;
  logic [N-1:0]   clic_irq_o;
  logic [7:0]     clic_irq_level_o;
  logic           ack;
  logic [5:0]     ack_id;
  logic           claim_valid_o;
  logic [5:0]     claim_id_o;

  int n_cmp;
  int n_bad;

  // Reference model: 0 = nothing requested, 1 = requesting m_id, 2 = gap cycle
  int       m_phase;
  int       m_id;
  int       m_lvl;
  bit       m_cv;
  int       m_cid;

  clic_irq_tx #(.NumSrc(N)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .irq_pending_i     (pend),
    .irq_enable_i      (en),
    .irq_level_i       (lvl),
    .clic_irq_o        (clic_irq_o),
    .clic_irq_level_o  (clic_irq_level_o),
    .clic_irq_ack_i    (ack),
    .clic_irq_ack_id_i (ack_id),
    .claim_valid_o     (claim_valid_o),
    .claim_id_o        (claim_id_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic int lv(int i);
    return int'(lvl[8*i +: 8]);
  endfunction

  function automatic bit cand(int i);
    return pend[i] && en[i] && (lv(i) != 0);
  endfunction

  // Highest level wins; scanning upwards with >= makes the higher id win ties.
  function automatic int best(int excl);
    int b  = -1;
    int bl = 0;
    for (int i = 0; i < N; i++) begin
      if (i != excl && cand(i) && lv(i) >= bl) begin
        b  = i;
        bl = lv(i);
      end
    end
    return b;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_id = 0; m_lvl = 0; m_cv = 0; m_cid = 0;
  endtask

  task automatic model_step();
    int b;
    m_cv = 0;
    if (ack) begin
      m_cv = 1; m_cid = int'(ack_id); m_phase = 0;
    end else if (m_phase == 1) begin
      b = best(m_id);
      if (!cand(m_id) || (b >= 0 && lv(b) > m_lvl)) m_phase = 2;
    end else begin
      b = best(-1);
      if (b >= 0) begin
        m_phase = 1; m_id = b; m_lvl = lv(b);
      end else begin
        m_phase = 0;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_irq();
    logic [N-1:0] v = '0;
    if (m_phase == 1) v[m_id] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] exp_lvl();
    return (m_phase == 1) ? 8'(m_lvl) : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    if (!rst_ni) model_reset();
    else model_step();
    #1;
  endtask

  task automatic clear_all();
    pend = '0; en = '0; lvl = '0; ack = 1'b0; ack_id = '0;
    tick(); tick(); tick();
  endtask

  task automatic set_src(int i, int l);
    pend[i] = 1'b1; en[i] = 1'b1; lvl[8*i +: 8] = 8'(l);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; pend = '0; en = '0; lvl = '0; ack = 1'b0; ack_id = '0;
    model_reset();
    #1;
    n_cmp++;
    if (clic_irq_o !== '0 || clic_irq_level_o !== 8'h00) begin
      n_bad++; $display("FAIL reset_req: irq=%h lvl=%h required 0/0", clic_irq_o, clic_irq_level_o);
    end
    n_cmp++;
    if (claim_valid_o !== 1'b0 || claim_id_o !== 6'd0) begin
      n_bad++; $display("FAIL reset_claim: v=%b id=%0d required 0/0", claim_valid_o, claim_id_o);
    end
    tick(); tick();
    #3 rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_all();
    set_src(5, 'h40);
    tick();
    n_cmp++;
    if (clic_irq_o !== (64'd1 << 5) || clic_irq_level_o !== 8'h40) begin
      n_bad++; $display("FAIL basic_req: irq=%h lvl=%h required %h/40", clic_irq_o, clic_irq_level_o, 64'd1 << 5);
    end
    ack = 1'b1; ack_id = 6'd5;
    tick();
    ack = 1'b0; pend[5] = 1'b0;
    n_cmp++;
    if (clic_irq_o !== '0 || claim_valid_o !== 1'b1 || claim_id_o !== 6'd5) begin
      n_bad++; $display("FAIL basic_claim: irq=%h v=%b id=%0d required 0/1/5", clic_irq_o, claim_valid_o, claim_id_o);
    end
    tick();
    n_cmp++;
    if (claim_valid_o !== 1'b0 || clic_irq_o !== '0 || clic_irq_level_o !== 8'h00) begin
      n_bad++; $display("FAIL basic_after: v=%b irq=%h lvl=%h required 0/0/0", claim_valid_o, clic_irq_o, clic_irq_level_o);
    end
  endtask

  task automatic test_tie();
    clear_all();
    set_src(3, 'h20); set_src(9, 'h20);
    tick();
    n_cmp++;
    if (clic_irq_o !== (64'd1 << 9) || clic_irq_level_o !== 8'h20) begin
      n_bad++; $display("FAIL tie_req: irq=%h lvl=%h required %h/20", clic_irq_o, clic_irq_level_o, 64'd1 << 9);
    end
    set_src(12, 'h20);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (clic_irq_o !== (64'd1 << 9) || clic_irq_level_o !== 8'h20) begin
        n_bad++; $display("FAIL tie_hold: irq=%h lvl=%h required %h/20", clic_irq_o, clic_irq_level_o, 64'd1 << 9);
      end
    end
  endtask

  task automatic test_preempt();
    set_src(2, 'h80);
    tick();
    n_cmp++;
    if (clic_irq_o !== '0 || clic_irq_level_o !== 8'h00) begin
      n_bad++; $display("FAIL preempt_gap: irq=%h lvl=%h required 0/0", clic_irq_o, clic_irq_level_o);
    end
    tick();
    n_cmp++;
    if (clic_irq_o !== (64'd1 << 2) || clic_irq_level_o !== 8'h80) begin
      n_bad++; $display("FAIL preempt_new: irq=%h lvl=%h required %h/80", clic_irq_o, clic_irq_level_o, 64'd1 << 2);
    end
  endtask

  task automatic test_withdraw();
    clear_all();
    set_src(5, 'h40);
    tick();
    en[5] = 1'b0;
    tick();
    n_cmp++;
    if (clic_irq_o !== '0 || claim_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL withdraw_kill: irq=%h v=%b required 0/0", clic_irq_o, claim_valid_o);
    end
    tick();
    n_cmp++;
    if (clic_irq_o !== '0 || claim_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL withdraw_idle: irq=%h v=%b required 0/0", clic_irq_o, claim_valid_o);
    end
    en[5] = 1'b1;
    tick();
    n_cmp++;
    if (clic_irq_o !== (64'd1 << 5)) begin
      n_bad++; $display("FAIL withdraw_rereq: irq=%h required %h", clic_irq_o, 64'd1 << 5);
    end
    en[5] = 1'b0; ack = 1'b1; ack_id = 6'd5;
    tick();
    ack = 1'b0;
    n_cmp++;
    if (clic_irq_o !== '0 || claim_valid_o !== 1'b1 || claim_id_o !== 6'd5) begin
      n_bad++; $display("FAIL ack_over_kill: irq=%h v=%b id=%0d required 0/1/5", clic_irq_o, claim_valid_o, claim_id_o);
    end
    tick();
    n_cmp++;
    if (clic_irq_o !== '0 || claim_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL ack_over_kill_after: irq=%h v=%b required 0/0", clic_irq_o, claim_valid_o);
    end
  endtask

  task automatic test_level0();
    clear_all();
    set_src(7, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if (clic_irq_o !== '0 || clic_irq_level_o !== 8'h00) begin
        n_bad++; $display("FAIL level0: irq=%h lvl=%h required 0/0", clic_irq_o, clic_irq_level_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_all();
    set_src(5, 'h40);
    tick();
    n_cmp++;
    if (clic_irq_o !== (64'd1 << 5)) begin
      n_bad++; $display("FAIL rstmid_req: irq=%h required %h", clic_irq_o, 64'd1 << 5);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (clic_irq_o !== '0 || clic_irq_level_o !== 8'h00 || claim_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_async: irq=%h lvl=%h v=%b required 0/0/0", clic_irq_o, clic_irq_level_o, claim_valid_o);
    end
    tick();
    n_cmp++;
    if (clic_irq_o !== '0 || claim_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_hold: irq=%h v=%b required 0/0", clic_irq_o, claim_valid_o);
    end
    #2 rst_ni = 1'b1;
    tick();
    n_cmp++;
    if (clic_irq_o !== (64'd1 << 5) || clic_irq_level_o !== 8'h40 || claim_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_reissue: irq=%h lvl=%h v=%b required %h/40/0", clic_irq_o, clic_irq_level_o, claim_valid_o, 64'd1 << 5);
    end
  endtask

  task automatic test_random();
    int lv_tab [5] = '{0, 'h10, 'h20, 'h30, 'h80};
    int id;
    clear_all();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          id = int'($urandom_range(0, N-1));
          pend[id] = 1'($urandom_range(0, 1));
          en[id]   = ($urandom_range(0, 3) != 0);
          lvl[8*id +: 8] = 8'(lv_tab[$urandom_range(0, 4)]);
        end
      end
      ack = ($urandom_range(0, 7) == 0);
      ack_id = (m_phase == 1 && $urandom_range(0, 3) != 0) ? 6'(m_id) : 6'($urandom_range(0, N-1));
      tick();
      n_cmp++;
      if (clic_irq_o !== exp_irq() || clic_irq_level_o !== exp_lvl()) begin
        n_bad++; $display("FAIL rand_req cyc%0d: irq=%h lvl=%h required %h/%h", cyc, clic_irq_o, clic_irq_level_o, exp_irq(), exp_lvl());
      end
      n_cmp++;
      if (claim_valid_o !== m_cv || (m_cv && claim_id_o !== 6'(m_cid))) begin
        n_bad++; $display("FAIL rand_claim cyc%0d: v=%b id=%0d required %b/%0d", cyc, claim_valid_o, claim_id_o, m_cv, m_cid);
      end
      n_cmp++;
      if (!$onehot0(clic_irq_o) || (clic_irq_o == '0 && clic_irq_level_o != 8'h00)) begin
        n_bad++; $display("FAIL rand_onehot cyc%0d: irq=%h lvl=%h required onehot0 and lvl 0 when idle", cyc, clic_irq_o, clic_irq_level_o);
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_tie();
    test_preempt();
    test_withdraw();
    test_level0();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
